// File: rtl/mux_nto1_scan.sv
// Registered N-channel, W-bit multiplexer with manual select and round-robin scan.
// Each scanned channel is held for DWELL enabled cycles.
module mux_nto1_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      en,
  output logic [WIDTH-1:0]          dout,
  output logic                      dout_valid,
  output logic [SEL_W-1:0]          ch_idx,
  output logic                      wrap,
  output logic                      sel_err
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);
  localparam logic [DW_W-1:0]  LAST_DW = DW_W'(DWELL - 1);

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t            state_r;
  logic [SEL_W-1:0]  ptr_r;
  logic [DW_W-1:0]   dwell_r;
  logic              sel_ok_s;
  logic [WIDTH-1:0]  sel_data_s;
  logic [WIDTH-1:0]  scan_data_s;

  function automatic logic [WIDTH-1:0] pick(
    input logic [CHANNELS*WIDTH-1:0] bus,
    input logic [SEL_W-1:0]          idx
  );
    logic [WIDTH-1:0] res;
    res = {WIDTH{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      res = (idx == SEL_W'(k)) ? bus[k*WIDTH +: WIDTH] : res;
    end
    return res;
  endfunction

  // 32-bit compare so CHANNELS == 2**SEL_W is handled without truncation
  assign sel_ok_s    = ({{(32-SEL_W){1'b0}}, sel} < 32'(CHANNELS));
  assign sel_data_s  = pick(din, sel);
  assign scan_data_s = pick(din, ptr_r);

  // Mode FSM, scan pointer/dwell counter and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_MANUAL;
      ptr_r      <= {SEL_W{1'b0}};
      dwell_r    <= {DW_W{1'b0}};
      dout       <= {WIDTH{1'b0}};
      dout_valid <= 1'b0;
      ch_idx     <= {SEL_W{1'b0}};
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
    end else if (!en) begin
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
    end else if (state_t'(mode) != state_r) begin
      // one bubble edge on every mode change; dout and ch_idx hold
      state_r    <= state_t'(mode);
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
      sel_err    <= 1'b0;
      if (mode) begin
        ptr_r   <= {SEL_W{1'b0}};
        dwell_r <= {DW_W{1'b0}};
      end else begin
        ptr_r   <= ptr_r;
        dwell_r <= dwell_r;
      end
    end else begin
      case (state_r)
        ST_MANUAL: begin
          wrap <= 1'b0;
          if (sel_ok_s) begin
            dout       <= sel_data_s;
            ch_idx     <= sel;
            dout_valid <= 1'b1;
            sel_err    <= 1'b0;
          end else begin
            dout       <= {WIDTH{1'b0}};
            dout_valid <= 1'b0;
            sel_err    <= 1'b1;
          end
        end
        ST_SCAN: begin
          dout       <= scan_data_s;
          ch_idx     <= ptr_r;
          dout_valid <= 1'b1;
          sel_err    <= 1'b0;
          if (dwell_r == LAST_DW) begin
            dwell_r <= {DW_W{1'b0}};
            if (ptr_r == LAST_CH) begin
              ptr_r <= {SEL_W{1'b0}};
              wrap  <= 1'b1;
            end else begin
              ptr_r <= ptr_r + SEL_W'(1);
              wrap  <= 1'b0;
            end
          end else begin
            dwell_r <= dwell_r + DW_W'(1);
            wrap    <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_MANUAL;
          dout_valid <= 1'b0;
          wrap       <= 1'b0;
          sel_err    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed self-checking bench for mux_nto1_scan (CHANNELS=6, DWELL=3, WIDTH=8).
module tb_mux_nto1_scan;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 6;
  localparam int SEL_W    = 3;
  localparam int DWELL    = 3;

  logic                      clk;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] din;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic                      en;
  logic [WIDTH-1:0]          dout;
  logic                      dout_valid;
  logic [SEL_W-1:0]          ch_idx;
  logic                      wrap;
  logic                      sel_err;

  int checks   = 0;
  int failures = 0;

  mux_nto1_scan #(
    .WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W), .DWELL(DWELL)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .mode(mode), .sel(sel), .en(en),
    .dout(dout), .dout_valid(dout_valid), .ch_idx(ch_idx),
    .wrap(wrap), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_dout, input logic e_valid,
                         input logic [2:0] e_ch, input logic e_wrap, input logic e_err);
    chk({tag, ".dout"},  32'(dout),       32'(e_dout));
    chk({tag, ".valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, ".ch"},    32'(ch_idx),     32'(e_ch));
    chk({tag, ".wrap"},  32'(wrap),       32'(e_wrap));
    chk({tag, ".err"},   32'(sel_err),    32'(e_err));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] exp_ch;
    rst  = 1'b1;
    en   = 1'b0;
    mode = 1'b0;
    sel  = 3'd0;
    for (int k = 0; k < CHANNELS; k++) din[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
    step();
    step();
    rst = 1'b0;
    chk_all("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    // start a scan, then reset asynchronously mid-scan
    mode = 1'b1;
    en   = 1'b1;
    step();
    step();
    chk_all("prescan", 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    mode = 1'b0;
    sel  = 3'd3;
    din[3*WIDTH +: WIDTH] = 8'hA5;
    step();
    chk_all("post_rst", 8'hA5, 1'b1, 3'd3, 1'b0, 1'b0);
    din[3*WIDTH +: WIDTH] = 8'h13;

    // manual sweep over all legal channels
    for (int s = 0; s < CHANNELS; s++) begin
      sel = 3'(s);
      step();
      chk_all($sformatf("man%0d", s), 8'h10 + 8'(s), 1'b1, 3'(s), 1'b0, 1'b0);
    end

    // out-of-range selects hold ch_idx from the last legal sample
    sel = 3'd2;
    step();
    chk_all("man2b", 8'h12, 1'b1, 3'd2, 1'b0, 1'b0);
    sel = 3'd6;
    step();
    chk_all("oor6", 8'h00, 1'b0, 3'd2, 1'b0, 1'b1);
    sel = 3'd7;
    step();
    chk_all("oor7", 8'h00, 1'b0, 3'd2, 1'b0, 1'b1);
    sel = 3'd5;
    step();
    chk_all("rec5", 8'h15, 1'b1, 3'd5, 1'b0, 1'b0);

    // enter scan: bubble, then a full sweep plus a partial one; sel ignored
    mode = 1'b1;
    sel  = 3'd7;
    step();
    chk_all("scan_bub", 8'h15, 1'b0, 3'd5, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      step();
      exp_ch = 3'((i / DWELL) % CHANNELS);
      chk_all($sformatf("scan%0d", i), 8'h10 + 8'(exp_ch), 1'b1, exp_ch,
              (i % (CHANNELS * DWELL)) == (CHANNELS * DWELL - 1), 1'b0);
    end

    // pause at pointer 2 / dwell 1; a mode toggle while paused must be ignored
    en = 1'b0;
    for (int p = 0; p < 5; p++) begin
      mode = (p == 1 || p == 2) ? 1'b0 : 1'b1;
      step();
      chk_all($sformatf("pause%0d", p), 8'h12, 1'b0, 3'd2, 1'b0, 1'b0);
    end
    mode = 1'b1;
    en   = 1'b1;
    step();
    chk_all("resume0", 8'h12, 1'b1, 3'd2, 1'b0, 1'b0);
    step();
    chk_all("resume1", 8'h12, 1'b1, 3'd2, 1'b0, 1'b0);
    step();
    chk_all("resume2", 8'h13, 1'b1, 3'd3, 1'b0, 1'b0);

    // back to manual, then re-enter scan from channel 0
    mode = 1'b0;
    sel  = 3'd4;
    step();
    chk_all("man_bub", 8'h13, 1'b0, 3'd3, 1'b0, 1'b0);
    step();
    chk_all("man_ret", 8'h14, 1'b1, 3'd4, 1'b0, 1'b0);
    mode = 1'b1;
    step();
    chk_all("rescan_bub", 8'h14, 1'b0, 3'd4, 1'b0, 1'b0);
    step();
    chk_all("rescan0", 8'h10, 1'b1, 3'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
